// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider controller.
// Accepts a dividend/divisor pair, produces one quotient bit per clock and
// returns quotient, remainder and a divide-by-zero flag over valid/ready.
// Optional build macro DIV_SIGNED_EN: two's-complement operands, with a
// one-cycle FIXUP state that applies the result signs (truncation toward zero).
module div_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2, S_FIXUP = 2'd3} state_t;

    // Two's-complement negation; MIN maps to itself, which yields MIN / -1 = MIN.
    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Magnitude of a two's-complement value, read back as unsigned.
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? f_neg(v) : v;
    endfunction
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2} state_t;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;     // partial remainder
    logic [WIDTH-1:0] r_dvd;     // dividend shift register, fills with quotient bits
    logic [WIDTH-1:0] r_dvs;     // latched divisor (magnitude in signed build)
`ifdef DIV_SIGNED_EN
    logic             r_sign_q;
    logic             r_sign_r;
`endif

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic             w_last;
    logic             w_div_zero;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    // The shifted value is WIDTH+1 bits; when it is >= divisor the difference
    // is below the divisor and therefore fits back into WIDTH bits.
    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? (w_shift[WIDTH-1:0] - r_dvs) : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_dvd[WIDTH-2:0], w_ge};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_div_zero = (divisor == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and handshake/status outputs decoded from the state.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_next = w_div_zero ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
`ifdef DIV_SIGNED_EN
                    w_next = S_FIXUP;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            S_FIXUP: begin
                w_next = abort ? S_IDLE : S_DONE;
            end
`endif
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Iteration counter and result registers; results change only when an
    // operation completes, so an aborted operation leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cnt <= '0;
                        if (w_div_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    if (!abort) begin
                        r_cnt <= r_cnt + CNT_W'(1);
`ifndef DIV_SIGNED_EN
                        if (w_last) begin
                            quotient    <= w_quo_next;
                            remainder   <= w_rem_next;
                            div_by_zero <= 1'b0;
                        end
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                S_FIXUP: begin
                    if (!abort) begin
                        quotient    <= r_sign_q ? f_neg(r_dvd) : r_dvd;
                        remainder   <= r_sign_r ? f_neg(r_rem) : r_rem;
                        div_by_zero <= 1'b0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Working datapath: operand capture on accept, one shift/subtract per ITER cycle.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && in_valid) begin
            r_rem <= '0;
`ifdef DIV_SIGNED_EN
            r_dvd    <= f_abs(dividend);
            r_dvs    <= f_abs(divisor);
            r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_sign_r <= dividend[WIDTH-1];
`else
            r_dvd <= dividend;
            r_dvs <= divisor;
`endif
        end else if (r_state == S_ITER) begin
            r_rem <= w_rem_next;
            r_dvd <= w_quo_next;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed scenarios plus randomized
// operations compared against a plain-arithmetic reference model.
// Honours DIV_SIGNED_EN for both the model and the extra signed cases.
module tb_div_sequencer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         abort = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] last_q;
    logic [W-1:0] last_r;
    logic         last_z;

    div_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain division. lat = clock edges after the accept edge
    // before out_valid is seen (0 means visible right after the accept edge).
    task automatic model(input logic [W-1:0] p, input logic [W-1:0] q,
                         output logic [W-1:0] eq, output logic [W-1:0] er,
                         output logic ez, output int lat);
        if (q == '0) begin
            eq = '1; er = p; ez = 1'b1; lat = 0;
        end else begin
`ifdef DIV_SIGNED_EN
            int ps, qs;
            ps = $signed(p);
            qs = $signed(q);
            eq = W'(ps / qs);
            er = W'(ps % qs);
            lat = W + 1;
`else
            eq = p / q;
            er = p % q;
            lat = W;
`endif
            ez = 1'b0;
        end
    endtask

    // Full transaction: accept, measure latency, optionally hold out_ready low
    // for 'hold' cycles (with an ignored in_valid pulse if 'poke'), then release.
    task automatic run_op(input logic [W-1:0] p, input logic [W-1:0] q,
                          input int hold, input bit poke);
        logic [W-1:0] eq, er;
        logic ez;
        int elat, lat;
        model(p, q, eq, er, ez, elat);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'(1));
        dividend = p; divisor = q; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = W'($urandom); divisor = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 3 * W) begin
            check("busy_iter", 64'(busy), 64'(1));
            check("in_ready_iter", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(elat));
        check("quotient", 64'(quotient), 64'(eq));
        check("remainder", 64'(remainder), 64'(er));
        check("div_by_zero", 64'(div_by_zero), 64'(ez));
        check("busy_done", 64'(busy), 64'(1));
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 1) begin
                in_valid = 1'b1; dividend = 16'd77; divisor = 16'd5;
                check("in_ready_done", 64'(in_ready), 64'(0));
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_quotient", 64'(quotient), 64'(eq));
            check("hold_remainder", 64'(remainder), 64'(er));
            check("hold_dbz", 64'(div_by_zero), 64'(ez));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 64'(out_valid), 64'(0));
        check("release_in_ready", 64'(in_ready), 64'(1));
        check("release_busy", 64'(busy), 64'(0));
        last_q = eq; last_r = er; last_z = ez;
    endtask

    initial begin
        bit seen;
        int sel;
        logic [W-1:0] rq;

        // Asynchronous reset with no clock edge needed.
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_quotient", 64'(quotient), 64'(0));
        check("rst_remainder", 64'(remainder), 64'(0));
        check("rst_dbz", 64'(div_by_zero), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'(1));

        run_op(16'd100, 16'd7, 0, 1'b0);
        run_op(16'd1234, 16'd0, 0, 1'b0);
        run_op(16'd65535, 16'd1, 0, 1'b0);
        run_op(16'd50000, 16'd300, 5, 1'b1);

        // Abort on the 5th ITER cycle: no result, outputs unchanged.
        @(negedge clk);
        dividend = 16'd9; divisor = 16'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(1));
        check("abort_quotient_kept", 64'(quotient), 64'(last_q));
        check("abort_remainder_kept", 64'(remainder), 64'(last_r));
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 64'(seen), 64'(0));
        run_op(16'd9, 16'd2, 0, 1'b0);

        // Reset in the middle of ITER, away from any clock edge.
        @(negedge clk);
        dividend = 16'd1000; divisor = 16'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_quotient", 64'(quotient), 64'(0));
        check("midrst_remainder", 64'(remainder), 64'(0));
        check("midrst_dbz", 64'(div_by_zero), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd3, 16'd5, 0, 1'b0);

`ifdef DIV_SIGNED_EN
        run_op(16'hFF9C, 16'd7, 0, 1'b0);
        run_op(16'h8000, 16'hFFFF, 0, 1'b0);
        run_op(16'd7, 16'hFFFE, 0, 1'b0);
        run_op(16'h8000, 16'd0, 0, 1'b0);
`endif

        // Randomized operations with random backpressure.
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0:       rq = '0;
                1:       rq = 16'd1;
                2:       rq = W'($urandom_range(1, 15));
                3:       rq = 16'hFFFF;
                default: rq = W'($urandom);
            endcase
            run_op(W'($urandom), rq, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
